// File: rtl/if_id_buf_pkg.sv
// Shared pipeline types for the IF/ID decoupling buffer: entry layout,
// datapath widths, bubble encoding and a saturating counter helper.
package if_id_buf_pkg;

   localparam int WORD      = 64;
   localparam int INST_SIZE = 32;
   localparam int PERF_W    = 32;

   typedef struct packed {
      logic [WORD-1:0]      pc;
      logic [WORD-1:0]      pc_incr;
      logic [INST_SIZE-1:0] inst;
   } if_id_entry_t;

   localparam logic [INST_SIZE-1:0] NOP_INST = 32'h0;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (v == '1) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/if_id_fifo_ctrl.sv
// Pointer/occupancy control for the IF/ID buffer. Flush beats push and pop;
// readiness is derived from registered occupancy only, never from id_ready.
module if_id_fifo_ctrl
   import if_id_buf_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_valid,
   input  logic          id_ready,
   input  logic          flush,
   output logic          if_ready,
   output logic          id_valid,
   output logic          push,
   output logic [PW-1:0] wr_ptr,
   output logic [PW-1:0] rd_ptr
);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          pop;

   assign if_ready = (count_q < CW'(DEPTH));
   assign id_valid = (count_q != '0);
   assign push     = if_valid & if_ready & ~flush;
   assign pop      = id_valid & id_ready & ~flush;
   assign wr_ptr   = wr_ptr_q;
   assign rd_ptr   = rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow.
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/if_id_buf.sv
// IF/ID decoupling FIFO with valid/ready toward ID and bubble-zeroed outputs.
// Optional performance counters are enabled by defining IF_ID_BUF_PERF_CNT_EN.
module if_id_buf
   import if_id_buf_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_valid,
   output logic                 if_ready,
   input  logic [WORD-1:0]      if_pc,
   input  logic [WORD-1:0]      if_pc_incr,
   input  logic [INST_SIZE-1:0] if_inst,
   input  logic                 flush,
   output logic                 id_valid,
   input  logic                 id_ready,
   output logic [WORD-1:0]      id_pc,
   output logic [WORD-1:0]      id_pc_incr,
   output logic [INST_SIZE-1:0] id_inst
`ifdef IF_ID_BUF_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0]    stall_cnt,
   output logic [PERF_W-1:0]    flush_cnt
`endif
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high and flush is low; valid never depends on ready in either direction.

   logic          push;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   if_id_entry_t  mem_q [DEPTH];
   if_id_entry_t  head;

   if_id_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .if_valid (if_valid),
      .id_ready (id_ready),
      .flush    (flush),
      .if_ready (if_ready),
      .id_valid (id_valid),
      .push     (push),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr)
   );

   // Storage carries no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr] <= '{pc: if_pc, pc_incr: if_pc_incr, inst: if_inst};
      end
   end

   assign head       = mem_q[rd_ptr];
   assign id_pc      = id_valid ? head.pc      : '0;
   assign id_pc_incr = id_valid ? head.pc_incr : '0;
   assign id_inst    = id_valid ? head.inst    : NOP_INST;

`ifdef IF_ID_BUF_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((id_valid & ~id_ready) | (if_valid & ~if_ready)) stall_cnt_d = sat_inc(stall_cnt_q);
      // Only flushes that actually discard something are counted.
      if (flush & (id_valid | if_valid)) flush_cnt_d = sat_inc(flush_cnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   // Counters absent; the datapath above is unaffected.
`endif

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Decoupling buffer between the IF stage and the ID stage of the LEGv8 pipeline.
- Captures {pc, pc_incr, inst} from IF (pc_incr = pc + 4, inst read from inst_mem at pc) into a small FIFO. Presents the oldest entry to ID with a valid/ready handshake.
- Supports ID back-pressure (load-use stall) and a flush on a taken branch (PCSrc != 0 in EX).
- Replaces a bare IF/ID register, so an ID stall no longer has to freeze PC combinationally.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, >= 2.
- WORD, `WORD (64), PC width.
- INST_SIZE, `INST_SIZE (32), instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_valid  input  1  IF presents a fetched instruction this cycle.
- if_ready  output  1  buffer can accept; equals (count < DEPTH), registered-state only.
- if_pc  input  WORD  PC of fetched instruction.
- if_pc_incr  input  WORD  PC + 4.
- if_inst  input  INST_SIZE  fetched instruction.
- flush  input  1  discard all buffered and incoming entries.
- id_valid  output  1  head entry is valid.
- id_ready  input  1  ID consumes head this cycle.
- id_pc  output  WORD  head PC.
- id_pc_incr  output  WORD  head PC + 4.
- id_inst  output  INST_SIZE  head instruction.

Behaviour:
- Storage: DEPTH-entry array; wr_ptr, rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (async, rst=1): wr_ptr=rd_ptr=count=0. id_valid=0, if_ready=1, id_pc=id_pc_incr=id_inst=0. Array contents don't-care.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & id_ready & ~flush.
- Counter update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Latency: an entry pushed at rising edge N is visible on id_* after edge N (1 cycle). There is no combinational IF-to-ID bypass.
- id_valid = (count != 0).
- id_pc, id_pc_incr, id_inst = head entry when id_valid, else forced to 0. Zero is the NOP/bubble encoding for ID.
- Stall: with id_ready=0, id_* stay bit-stable while id_valid=1. IF keeps pushing until full.
- Full: if_ready=0 when count==DEPTH, even if id_ready=1 that cycle (no ready pass-through). if_valid while full is ignored, and IF must hold PC.
- Empty: id_ready=1 with count==0 has no effect.
- Flush: synchronous. At the next edge count=0, wr_ptr=rd_ptr=0, and the same-cycle incoming entry is dropped. id_valid=0 the cycle after. flush overrides push and pop.
- rst asserted mid-operation: immediately returns to reset values regardless of clock.
- Pointer wrap: DEPTH-1 -> 0. Ordering is strictly FIFO.

Optional Feature:
- Macro: IF_ID_BUF_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], reset to 0.
  - stall_cnt increments each cycle with id_valid & ~id_ready, or if_valid & ~if_ready.
  - flush_cnt increments each cycle flush=1 with count!=0 or if_valid=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; functional behaviour identical.

Decomposition:
- WORD and INST_SIZE come from common.vh.
- Add to a shared pipeline package:
  - typedef if_id_entry_t {pc, pc_incr, inst}.
  - localparam NOP_INST = 32'h0.
- One sub-module: if_id_fifo_ctrl (pointers, count, push/pop/flush arbitration). Data array and output masking stay in if_id_buf.

Test Plan:
- Reset: assert rst mid-cycle with 2 entries held -> id_valid=0, id_inst=0, if_ready=1 immediately, before any clock edge.
- Streaming: push pc=0,4,8 (inst 1,2,3) with id_ready=1 -> id_inst=1,2,3 on consecutive cycles, each one cycle after its push.
- Stall/full: id_ready=0, push pc=0x10, 0x14 (inst 5,6) -> if_ready=0 after 2nd edge; id_inst stays 5. Push of inst 7 is ignored. Release id_ready -> outputs 5,6 in order.
- Simultaneous push/pop at count=1 -> count stays 1; wr_ptr/rd_ptr wrap correctly over 4 iterations (inst 8..11 delivered in order).
- Flush: with 2 entries held and if_valid=1 (inst 31), pulse flush -> next cycle id_valid=0, id_inst=0, count=0. Inst 31 never appears at ID.
- IF_ID_BUF_PERF_CNT_EN: 3 stall cycles plus 1 flush -> stall_cnt=3, flush_cnt=1. Build without the macro and run the same stimulus -> identical id_* traces.
